// File: rtl/ob_readout_streamer_pkg.sv
// Shared types and constants for the output-buffer readout streamer.
package ob_readout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } ob_rd_state_e;

    localparam int unsigned OB_RD_FIFO_DEPTH = 4;
    localparam int unsigned OB_RD_CNT_W      = $clog2(OB_RD_FIFO_DEPTH + 1);

endpackage

// File: rtl/ob_readout_streamer_if.sv
// Valid/ready row stream from the readout streamer to its consumer.
interface ob_readout_streamer_if #(
    parameter int unsigned DATA_WIDTH = 32
);

    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  last_o;

    modport master (
        output data_o,
        output valid_o,
        output last_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        input  last_o,
        output ready_i
    );

endinterface

// File: rtl/ob_readout_streamer_fifo.sv
// Small synchronous FIFO holding returned rows (data plus last flag).
module stream_fifo #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 33
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_FULL);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_ONE;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/ob_readout_streamer.sv
// Drains the output buffer SRAM after a matmul and streams one row per beat
// over valid/ready, with credit-based read issue into a 4-entry FIFO.
module ob_readout_streamer
    import ob_readout_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned COL         = 4,
    parameter int unsigned O_SIZE      = 512,
    parameter int unsigned MEM_C_WIDTH = WIDTH * COL,
    parameter int unsigned AW          = $clog2(O_SIZE)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [AW-1:0]          base_addr_i,
    input  logic [AW:0]            num_rows_i,
    output logic                   ob_mem_cenb_o,
    output logic                   ob_mem_wenb_o,
    output logic [AW-1:0]          ob_mem_addr_o,
    input  logic [MEM_C_WIDTH-1:0] ob_mem_data_i,
    ob_readout_streamer_if.master  strm,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned   CW         = OB_RD_CNT_W;
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(O_SIZE - 1);
    localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(OB_RD_FIFO_DEPTH);

    ob_rd_state_e state;
    ob_rd_state_e state_next;

    logic [AW:0]          count_q;
    logic [AW:0]          issue_cnt;
    logic [AW:0]          beat_cnt;
    logic [AW-1:0]        addr_q;
    logic [AW-1:0]        addr_next;
    logic                 cenb_q;
    logic                 inflight_q;
    logic                 last_bus_q;
    logic                 last_ret_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 issue;
    logic                 issue_last;
    logic                 credit_ok;
    logic                 fire;
    logic [CW:0]          occupancy;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [MEM_C_WIDTH:0] head;

    // Outstanding = FIFO entries + row returning this cycle + row on the bus;
    // a concurrent pop is deliberately not credited back.
    assign occupancy = {1'b0, fifo_count}
                     + {{CW{1'b0}}, inflight_q}
                     + {{CW{1'b0}}, !cenb_q};
    assign credit_ok = !fifo_full && (occupancy < CREDIT_MAX);
    assign addr_next = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;

    assign fire         = strm.valid_o && strm.ready_i;
    assign strm.valid_o = !fifo_empty;
    assign strm.data_o  = fifo_empty ? '0 : head[MEM_C_WIDTH-1:0];
    assign strm.last_o  = !fifo_empty && head[MEM_C_WIDTH];

    assign ob_mem_cenb_o = cenb_q;
    assign ob_mem_wenb_o = 1'b1;
    assign ob_mem_addr_o = addr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_last = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    if (num_rows_i == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = READ;
                        issue      = 1'b1;
                        issue_last = (num_rows_i == CNT_ONE);
                    end
                end
            end
            READ: begin
                if (issue_cnt == count_q) begin
                    state_next = DRAIN;
                end else if (credit_ok) begin
                    issue      = 1'b1;
                    issue_last = (issue_cnt == count_q - CNT_ONE);
                end
            end
            DRAIN: begin
                // The final beat leaving implies FIFO and read pipe are empty.
                if (fire && (beat_cnt == count_q - CNT_ONE)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            issue_cnt  <= '0;
            beat_cnt   <= '0;
            addr_q     <= '0;
            cenb_q     <= 1'b1;
            inflight_q <= 1'b0;
            last_bus_q <= 1'b0;
            last_ret_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cenb_q     <= !issue;
            inflight_q <= !cenb_q;
            last_bus_q <= issue && issue_last;
            last_ret_q <= last_bus_q;
            busy_q     <= (state_next != IDLE);
            done_q     <= (state_next == DONE);

            if (issue) begin
                addr_q <= (state == IDLE) ? base_addr_i : addr_next;
            end

            if (state == IDLE && start_i) begin
                count_q   <= num_rows_i;
                issue_cnt <= issue ? CNT_ONE : '0;
                beat_cnt  <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + CNT_ONE;
                end
                if (fire) begin
                    beat_cnt <= beat_cnt + CNT_ONE;
                end
            end
        end
    end

    stream_fifo #(
        .DEPTH      (OB_RD_FIFO_DEPTH),
        .DATA_WIDTH (MEM_C_WIDTH + 1)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (inflight_q),
        .wr_data ({last_ret_q, ob_mem_data_i}),
        .pop     (fire),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_ob_readout_streamer.sv
// Randomized bench for ob_readout_streamer against a row-list reference model.
module tb_ob_readout_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  base;
    logic [9:0]  num;
    logic        cenb;
    logic        wenb;
    logic [8:0]  addr;
    logic [31:0] rdata;
    logic        busy;
    logic        done;

    logic [31:0] mem_model [512];

    int unsigned tests = 0;
    int unsigned fails = 0;

    ob_readout_streamer_if #(.DATA_WIDTH(32)) strm ();

    ob_readout_streamer #(
        .WIDTH  (8),
        .COL    (4),
        .O_SIZE (512)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .base_addr_i   (base),
        .num_rows_i    (num),
        .ob_mem_cenb_o (cenb),
        .ob_mem_wenb_o (wenb),
        .ob_mem_addr_o (addr),
        .ob_mem_data_i (rdata),
        .strm          (strm),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM: data appears the cycle after the enable.
    always @(posedge clk) begin
        if (!cenb) begin
            rdata <= mem_model[addr];
        end
    end

    task automatic do_start(input logic [8:0] b, input logic [9:0] n);
        start = 1'b1;
        base  = b;
        num   = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        base = '0;
        num = '0;
        strm.ready_i = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (cenb !== 1'b1) begin fails++; $display("FAIL reset_cenb: got %b expected 1", cenb); end
        tests++; if (wenb !== 1'b1) begin fails++; $display("FAIL reset_wenb: got %b expected 1", wenb); end
        tests++; if (addr !== 9'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", addr); end
        tests++; if (strm.data_o !== 32'd0) begin fails++; $display("FAIL reset_data: got %h expected 0", strm.data_o); end
        tests++; if (strm.valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", strm.valid_o); end
        tests++; if (strm.last_o !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", strm.last_o); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // mode 0: ready high, cycle-exact timing; 1: ready 1,0,0 repeating;
    // 2: random ready; 3: ready high plus a stray start pulse in cycle 3.
    task automatic test_readout(input int unsigned b, input int unsigned n, input int unsigned mode);
        int unsigned cyc = 0;
        int unsigned reads = 0;
        int unsigned beats = 0;
        int unsigned dones = 0;
        int unsigned limit = 4 * n + 50;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        logic [31:0] exp_data;
        logic [8:0]  exp_addr;
        strm.ready_i = 1'b1;
        do_start(9'(b), 10'(n));
        while (cyc < limit && dones == 0) begin
            cyc++;
            start = (mode == 3 && cyc == 3);
            if (mode == 3 && cyc == 3) begin
                base = 9'(b + 77);
                num  = 10'(n + 3);
            end
            if (!cenb) begin
                exp_addr = 9'((b + reads) % 512);
                tests++;
                if (reads >= n || addr !== exp_addr) begin
                    fails++;
                    $display("FAIL read_addr: read %0d got addr %0d expected %0d (of %0d rows)", reads, addr, exp_addr, n);
                end
                reads++;
            end
            tests++;
            if (reads > beats + 4) begin
                fails++;
                $display("FAIL outstanding: got %0d reads outstanding expected at most 4", reads - beats);
            end
            if (prev_stall) begin
                tests++;
                if (strm.valid_o !== 1'b1 || strm.data_o !== prev_data || strm.last_o !== prev_last) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             strm.valid_o, strm.data_o, strm.last_o, prev_data, prev_last);
                end
            end
            if (mode == 0 || mode == 3) begin
                tests++;
                if (cenb !== (cyc > n) || strm.valid_o !== (cyc >= 3 && cyc <= n + 2) ||
                    done !== (cyc == n + 3) || busy !== (cyc <= n + 3)) begin
                    fails++;
                    $display("FAIL timing: cycle %0d got cenb=%b valid=%b done=%b busy=%b expected %b %b %b %b",
                             cyc, cenb, strm.valid_o, done, busy, (cyc > n),
                             (cyc >= 3 && cyc <= n + 2), (cyc == n + 3), (cyc <= n + 3));
                end
            end
            if (mode == 1) begin
                strm.ready_i = (cyc % 3 == 1);
            end else if (mode == 2) begin
                strm.ready_i = 1'($urandom_range(0, 1));
            end else begin
                strm.ready_i = 1'b1;
            end
            if (strm.valid_o && strm.ready_i) begin
                exp_data = mem_model[9'((b + beats) % 512)];
                tests++;
                if (beats >= n || strm.data_o !== exp_data || strm.last_o !== (beats == n - 1)) begin
                    fails++;
                    $display("FAIL beat: beat %0d got d=%h l=%b expected d=%h l=%b",
                             beats, strm.data_o, strm.last_o, exp_data, (beats == n - 1));
                end
                beats++;
            end
            prev_stall = strm.valid_o && !strm.ready_i;
            prev_data  = strm.data_o;
            prev_last  = strm.last_o;
            if (done) begin
                dones++;
                tests++;
                if (beats != n || reads != n) begin
                    fails++;
                    $display("FAIL done_count: got %0d beats %0d reads expected %0d each", beats, reads, n);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (dones == 0) begin
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles expected one (base %0d rows %0d)", cyc, b, n);
        end
    endtask

    task automatic test_basic();
        mem_model[0] = 32'h1111_1111;
        mem_model[1] = 32'h2222_2222;
        mem_model[2] = 32'h3333_3333;
        mem_model[3] = 32'h4444_4444;
        test_readout(0, 4, 0);
    endtask

    task automatic test_wrap();
        test_readout(510, 4, 0);
        test_readout(509, 7, 2);
    endtask

    task automatic test_stall();
        test_readout(5, 8, 1);
        test_readout(500, 20, 1);
    endtask

    task automatic test_zero_rows();
        do_start(9'd100, 10'd0);
        for (int c = 1; c <= 4; c++) begin
            tests++;
            if (done !== (c == 1) || busy !== (c == 1) || cenb !== 1'b1 || strm.valid_o !== 1'b0) begin
                fails++;
                $display("FAIL zero_rows: cycle %0d got done=%b busy=%b cenb=%b valid=%b expected %b %b 1 0",
                         c, done, busy, cenb, strm.valid_o, (c == 1), (c == 1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_restart_ignored();
        test_readout(300, 6, 3);
    endtask

    task automatic test_reset_abort();
        strm.ready_i = 1'b1;
        do_start(9'd200, 10'd16);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (cenb !== 1'b1 || wenb !== 1'b1 || addr !== 9'd0 || strm.data_o !== 32'd0 ||
            strm.valid_o !== 1'b0 || strm.last_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_outputs: got cenb=%b wenb=%b addr=%0d data=%h valid=%b last=%b busy=%b done=%b expected 1 1 0 0 0 0 0 0",
                     cenb, wenb, addr, strm.data_o, strm.valid_o, strm.last_o, busy, done);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests++;
            if (strm.valid_o !== 1'b0 || done !== 1'b0 || cenb !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_quiet: got valid=%b done=%b cenb=%b busy=%b expected 0 0 1 0",
                         strm.valid_o, done, cenb, busy);
            end
        end
        test_readout(420, 5, 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            test_readout($urandom_range(0, 511), $urandom_range(1, 24), 2);
        end
    endtask

    task automatic test_boundaries();
        test_readout(511, 1, 0);
        test_readout(37, 512, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_model[i] = $urandom;
        end
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_rows();
        test_restart_ignored();
        test_reset_abort();
        test_random();
        test_boundaries();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation time limit expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ob_readout_streamer.md
# ob_readout_streamer

Drains the output buffer SRAM after a matrix multiply completes and streams its rows out over a valid/ready interface, one COL×WIDTH row per beat. It sits directly downstream of the matrix multiply wrapper: it shares the output buffer memory port once the wrapper's `done_o` is high, and feeds the host/test interface.

## Interface
- `WIDTH`, 8, bits per element
- `COL`, 4, elements per row
- `O_SIZE`, 512, output buffer depth in rows
- `MEM_C_WIDTH`, WIDTH*COL, row width in bits
- `AW`, $clog2(O_SIZE), address width

Ports:
- `clk_i`  in  1  clock; single clock domain
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  one-cycle pulse; begins a readout when idle
- `base_addr_i`  in  AW  first row address, sampled with `start_i`
- `num_rows_i`  in  AW+1  row count 0..O_SIZE, sampled with `start_i`
- `ob_mem_cenb_o`  out  1  memory enable, active low
- `ob_mem_wenb_o`  out  1  write enable, active low; constant 1
- `ob_mem_addr_o`  out  AW  read address
- `ob_mem_data_i`  in  MEM_C_WIDTH  read data, one cycle after enable
- `data_o`  out  MEM_C_WIDTH  stream beat
- `valid_o`  out  1  beat valid
- `ready_i`  in  1  consumer ready
- `last_o`  out  1  marks the final beat; qualified by `valid_o`
- `busy_o`  out  1  high from accepted start until done
- `done_o`  out  1  one-cycle pulse after the last beat transfers

## Operation
- Reset values: `ob_mem_cenb_o`=1, `ob_mem_wenb_o`=1, `ob_mem_addr_o`=0, `data_o`=0, `valid_o`=0, `last_o`=0, `busy_o`=0, `done_o`=0. Reset also clears the state, counters and FIFO.
- The FSM has four states: IDLE, READ, DRAIN and DONE.
  - IDLE: on `start_i`, latch base and count. If count is 0, go to DONE. Otherwise go to READ.
  - READ: issue one read per cycle while credit > 0. Credit = 4 − FIFO occupancy − reads in flight; a pop in the same cycle is not counted. After the last read is issued, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to DONE.
  - DONE: assert `done_o` for one cycle, then go to IDLE.
- Addresses increment from the latched base and wrap modulo O_SIZE. For example, base 510 with 4 rows reads 510, 511, 0, 1.
- Read data is pushed into a 4-entry FIFO in the cycle it returns. The FIFO head drives `data_o` and `valid_o`.
- A beat transfers when `valid_o && ready_i`. `last_o` is high only on the beat whose index equals count−1.
- `start_i` outside IDLE is ignored. The latched parameters do not change mid-operation.
- Stream rule: once `valid_o` is asserted, `data_o`, `valid_o` and `last_o` hold until the beat is accepted.
- Reset during an operation aborts it immediately. There is no `done_o` pulse, and any in-flight read data is discarded.

## Timing
- Start-to-first-beat latency is 3 cycles. With `start_i` sampled at edge 0:
  - cycle 1: `cenb`=0 with `addr`=base
  - cycle 2: data arrives and is pushed into the FIFO
  - cycle 3: `valid_o`=1
- With `ready_i` held high, throughput is one beat per cycle. For N rows, beats appear in cycles 3..N+2 and `done_o` pulses in cycle N+3. `busy_o` is high in cycles 1..N+3.
- Zero-row start: `done_o` pulses in cycle 1, with no memory access and no beats.
- `ready_i` low stalls the stream. The FIFO never overflows, because the credit check blocks issue when occupancy plus in-flight reads reaches 4.
- `ob_mem_cenb_o` and `ob_mem_addr_o` are registered outputs. `done_o` is registered.

## Structure
- Shared package `ob_readout_pkg` holds:
  - the state enum `ob_rd_state_e` (IDLE, READ, DRAIN, DONE)
  - `OB_RD_FIFO_DEPTH` = 4
- Sub-module `stream_fifo`: a synchronous FIFO with parameters DEPTH and DATA_WIDTH. Its ports are push, pop, full, empty and count, and it carries data plus the last flag (MEM_C_WIDTH+1 bits).
- The top level holds the FSM, the address/issue counter, the beat counter, the in-flight tracking flag and the credit logic.

## Test plan
- Base 0, count 4, `ready_i`=1, memory rows 0x11111111..0x44444444 → four beats in cycles 3–6 in that order, `last_o` on beat 4, `done_o` in cycle 7.
- Base 510, count 4 → addresses 510, 511, 0, 1 in order, data matches those rows.
- Count 8 with `ready_i` toggling 1,0,0,1,… → no beat lost or duplicated, `data_o` stable while stalled, never more than 4 reads outstanding.
- Count 0 → `done_o` pulse at cycle 1, `ob_mem_cenb_o` stays 1, `valid_o` stays 0.
- `start_i` pulsed again mid-readout with different base/count → ignored, the original sequence completes unchanged.
- `rst_i` asserted in cycle 4 of a 16-row readout → next cycle shows all outputs at reset values. A fresh start then gives correct beats from the new base.
